// File: rtl/sensor_trigger_pkg.sv
// Shared definitions for the sensor pin blocks: state encoding, timing defaults
// and the result-width helper.
package sensor_trigger_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Simulation-friendly defaults; the board build overrides the trigger width.
    localparam int SIM_TRIG_WIDTH   = 10;
    localparam int BOARD_TRIG_WIDTH = 500;
    localparam int SIM_ECHO_TIMEOUT = 50;
    localparam int SIM_MAX_WIDTH    = 1000;
    localparam int SIM_HOLDOFF      = 20;
    localparam int CNT_BITS         = 16;

    function automatic int width_bits(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous sensor pin.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the raw pin
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_trigger.sv
// Pulse-echo sensor driver: emits a timed trigger pulse, then measures the echo
// high time with timeout and saturation, followed by a quiet holdoff period.
module sensor_trigger
    import sensor_trigger_pkg::*;
#(
    parameter int TRIG_WIDTH   = SIM_TRIG_WIDTH,
    parameter int ECHO_TIMEOUT = SIM_ECHO_TIMEOUT,
    parameter int MAX_WIDTH    = SIM_MAX_WIDTH,
    parameter int HOLDOFF      = SIM_HOLDOFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             echo_in,
    output logic                             trig_out,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [width_bits(MAX_WIDTH)-1:0] echo_width
);

    localparam int WW = width_bits(MAX_WIDTH);
    localparam int CW = CNT_BITS;
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_WIDTH - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);
    localparam logic [WW-1:0] W_MAX     = WW'(MAX_WIDTH);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WW-1:0]   wcnt, wcnt_nxt;
    logic [WW-1:0]   width_nxt;
    logic            trig_nxt, busy_nxt, done_nxt, timeout_nxt;
    logic            echo_s;

    sync_2ff u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .d     (echo_in),
        .q     (echo_s)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wcnt       <= '0;
            trig_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            echo_width <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wcnt       <= wcnt_nxt;
            trig_out   <= trig_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            timeout    <= timeout_nxt;
            echo_width <= width_nxt;
        end
    end

    // Next-state and next-output decode; cnt is shared by TRIG, WAIT and HOLD
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wcnt_nxt    = wcnt;
        trig_nxt    = trig_out;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        timeout_nxt = timeout;
        width_nxt   = echo_width;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_TRIG;
                    trig_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    trig_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    trig_nxt  = 1'b0;
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                // An echo already high on entry is taken as the rise
                if (echo_s) begin
                    state_nxt   = S_MEAS;
                    wcnt_nxt    = WW'(1);
                end else if (cnt == WAIT_LAST) begin
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    width_nxt   = '0;
                    state_nxt   = S_HOLD;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt     = cnt + CW'(1);
                end
            end
            S_MEAS: begin
                if (!echo_s) begin
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b0;
                    width_nxt   = wcnt;
                    state_nxt   = S_HOLD;
                    cnt_nxt     = '0;
                end else if (wcnt == W_MAX) begin
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    width_nxt   = W_MAX;
                    state_nxt   = S_HOLD;
                    cnt_nxt     = '0;
                end else begin
                    wcnt_nxt    = wcnt + WW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                trig_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sensor_trigger.sv
// Self-checking bench for sensor_trigger: table vectors, randomized echoes
// against a transaction-level timing model, and reset/holdoff sequences.
module tb_sensor_trigger;

    localparam int TW       = 10;
    localparam int ETO      = 50;
    localparam int MW       = 1000;
    localparam int HO       = 20;
    localparam int SYNC_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       echo_in = 1'b0;
    logic       trig_out, busy, done, timeout;
    logic [9:0] echo_width;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    sensor_trigger dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .echo_in    (echo_in),
        .trig_out   (trig_out),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .echo_width (echo_width)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int d;
        int len;
        int exp_w;
        int exp_to;
        int exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected result for an echo driven d cycles after trig falls, len cycles long
    function automatic void ref_model(input int d, input int len,
                                      output int w, output int to, output int lat);
        int rise;
        rise = d + SYNC_LAT + 1;
        if (d < 0 || len <= 0 || rise > ETO) begin
            w = 0; to = 1; lat = ETO;
        end else if (len > MW) begin
            w = MW; to = 1; lat = rise + MW;
        end else begin
            w = len; to = 0; lat = rise + len;
        end
    endfunction

    task automatic measure(input string name, input int d, input int len,
                           input int exp_w, input int exp_to, input int exp_lat);
        int  n_high, t_fall, d_cyc, w, to, k, after;
        bit  got;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({name, " busy_at_start"}, int'(busy), 1);
        n_high = 0;
        while (trig_out && n_high < TW + 5) begin
            n_high++;
            tick(1);
        end
        check({name, " trig_len"}, n_high, TW);
        t_fall = cyc;
        got = 1'b0; d_cyc = 0; w = 0; to = 0; k = 0; after = 0;
        fork
            begin
                if (d >= 0 && len > 0) begin
                    tick(d);
                    echo_in = 1'b1;
                    tick(len);
                    echo_in = 1'b0;
                end
            end
            begin
                for (int i = 0; i < ETO + MW + 200 && !got; i++) begin
                    tick(1);
                    if (done) begin
                        got = 1'b1; d_cyc = cyc; w = int'(echo_width); to = int'(timeout);
                    end
                end
                if (got) begin
                    tick(1);
                    after = int'(done);
                    k = 1;
                    while (busy && k < HO + 10) begin
                        tick(1);
                        k++;
                    end
                end
            end
        join
        check({name, " done_seen"}, int'(got), 1);
        check({name, " done_latency"}, d_cyc - t_fall, exp_lat);
        check({name, " echo_width"}, w, exp_w);
        check({name, " timeout"}, to, exp_to);
        check({name, " done_one_cycle"}, after, 0);
        check({name, " busy_drop"}, k, HO);
        tick(3);
    endtask

    initial begin
        int d, len, ew, eto, elat, n0, cnt_t, cnt_d, r1, r2, dc, w;
        bit got;

        vecs[0] = '{d: 5,  len: 37,   exp_w: 37,   exp_to: 0, exp_lat: 45};
        vecs[1] = '{d: -1, len: 0,    exp_w: 0,    exp_to: 1, exp_lat: 50};
        vecs[2] = '{d: 0,  len: 1,    exp_w: 1,    exp_to: 0, exp_lat: 4};
        vecs[3] = '{d: 47, len: 3,    exp_w: 3,    exp_to: 0, exp_lat: 53};
        vecs[4] = '{d: 48, len: 3,    exp_w: 0,    exp_to: 1, exp_lat: 50};
        vecs[5] = '{d: 2,  len: 1000, exp_w: 1000, exp_to: 0, exp_lat: 1005};
        vecs[6] = '{d: 2,  len: 1001, exp_w: 1000, exp_to: 1, exp_lat: 1005};
        vecs[7] = '{d: 1,  len: 1500, exp_w: 1000, exp_to: 1, exp_lat: 1004};

        reset = 1'b1;
        tick(3);
        check("reset trig_out", int'(trig_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset timeout", int'(timeout), 0);
        check("reset echo_width", int'(echo_width), 0);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) begin
            measure($sformatf("vec%0d", i), vecs[i].d, vecs[i].len,
                    vecs[i].exp_w, vecs[i].exp_to, vecs[i].exp_lat);
        end

        for (int i = 0; i < 10; i++) begin
            d   = int'($urandom_range(0, 55));
            len = int'($urandom_range(1, 1100));
            ref_model(d, len, ew, eto, elat);
            measure($sformatf("rand%0d_d%0d_l%0d", i, d, len), d, len, ew, eto, elat);
        end

        // Echo already high when WAIT_ECHO is entered
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n0 = cyc;
        tick(5);
        echo_in = 1'b1;
        tick(15);
        echo_in = 1'b0;
        got = 1'b0; dc = 0; w = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            if (done) begin
                got = 1'b1; dc = cyc; w = int'(echo_width);
            end
        end
        check("early_echo done_cycle", dc - n0, 23);
        check("early_echo width", w, 12);
        check("early_echo timeout", int'(timeout), 0);
        tick(HO + 5);

        // A start pulse during HOLDOFF produces no trigger
        start = 1'b1;
        tick(1);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick(1);
            if (done) got = 1'b1;
        end
        check("holdoff done_seen", int'(got), 1);
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cnt_t = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (trig_out) cnt_t++;
        end
        check("holdoff ignored_start", cnt_t, 0);
        check("holdoff idle_busy", int'(busy), 0);

        // Level-held start repeats after each holdoff
        start = 1'b1;
        r1 = -1; r2 = -1;
        for (int i = 0; i < 10 && r1 < 0; i++) begin
            tick(1);
            if (trig_out) r1 = cyc;
        end
        for (int i = 0; i < 20 && trig_out; i++) tick(1);
        for (int i = 0; i < 200 && r2 < 0; i++) begin
            tick(1);
            if (trig_out) r2 = cyc;
        end
        start = 1'b0;
        check("level_start period", r2 - r1, TW + ETO + HO + 1);
        for (int i = 0; i < 200 && busy; i++) tick(1);
        check("level_start idle", int'(busy), 0);
        tick(3);

        // Reset during MEASURE
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 20 && trig_out; i++) tick(1);
        echo_in = 1'b1;
        tick(20);
        reset = 1'b1;
        tick(1);
        check("rst_meas trig_out", int'(trig_out), 0);
        check("rst_meas busy", int'(busy), 0);
        check("rst_meas done", int'(done), 0);
        check("rst_meas timeout", int'(timeout), 0);
        check("rst_meas echo_width", int'(echo_width), 0);
        reset = 1'b0;
        echo_in = 1'b0;
        cnt_d = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (done || busy) cnt_d++;
        end
        check("rst_meas quiet", cnt_d, 0);

        // Reset during TRIG after a valid result
        measure("pre_rst_trig", 5, 37, 37, 0, 45);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("rst_trig trig_out", int'(trig_out), 0);
        check("rst_trig busy", int'(busy), 0);
        check("rst_trig echo_width", int'(echo_width), 0);
        check("rst_trig timeout", int'(timeout), 0);
        reset = 1'b0;
        cnt_d = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (done || trig_out) cnt_d++;
        end
        check("rst_trig quiet", cnt_d, 0);
        measure("post_reset", 5, 37, 37, 0, 45);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
